reg_writeback_unit: RTL and testbench

//   Write-side initiator for the MIPS register file write port. Accepts results

---
 rtl/reg_writeback_unit_if.sv | 45 ++++
 rtl/reg_writeback_unit.sv | 132 +++++++++++++
 tb/tb_reg_writeback_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_unit_if.sv
`default_nettype none
// ============================================================================
//  Interface : reg_writeback_unit_if
//  Purpose   : Producer handshakes (ALU and load results) and the register
//              file write port of the writeback unit, bundled together.
//  Revision  : 1.0  initial release
// ============================================================================
interface reg_writeback_unit_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    // ALU result channel
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;

    // Memory-load result channel
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_reg;
    logic [DATA_W-1:0] mem_data;

    // Register file write port
    logic              RegWriteSig;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;

    // The writeback unit: consumes results, drives the write port
    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  mem_valid, mem_reg, mem_data,
        output alu_ready, mem_ready,
        output RegWriteSig, writeReg, writeData
    );

    // Producers plus the register file observing the port
    modport master (
        output alu_valid, alu_reg, alu_data,
        output mem_valid, mem_reg, mem_data,
        input  alu_ready, mem_ready,
        input  RegWriteSig, writeReg, writeData
    );
endinterface
`default_nettype wire

// File: rtl/reg_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module    : reg_writeback_unit
//  Purpose   : Queues ALU and load results in an in-order FIFO and retires
//              one register-file write per cycle. Exports a pending-write
//              mask and a read-after-write stall for the decode stage.
//  Revision  : 1.0  initial release
// ============================================================================
module reg_writeback_unit #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    reg_writeback_unit_if.slave          bus,
    input  wire logic                    wr_hold,
    input  wire logic [ADDR_W-1:0]       rd_reg1,
    input  wire logic [ADDR_W-1:0]       rd_reg2,
    output logic                         stall,
    output logic [(1<<ADDR_W)-1:0]       pending_mask,
    output logic [$clog2(DEPTH):0]       count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

    // FIFO storage and bookkeeping
    logic [ADDR_W-1:0] r_fifo_reg  [DEPTH];
    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Registered write port
    logic              r_we;
    logic [ADDR_W-1:0] r_wreg;
    logic [DATA_W-1:0] r_wdata;

    logic              w_full;
    logic              w_take_mem;
    logic              w_take_alu;
    logic [ADDR_W-1:0] w_in_reg;
    logic [DATA_W-1:0] w_in_data;
    logic              w_push;
    logic              w_pop;
    logic [DEPTH-1:0]  w_entry_valid;
    logic [NREG-1:0]   w_mask;

    // Full is judged on the occupancy before this edge's pop, so a drain
    // never opens a slot for a push on the same edge.
    assign w_full        = (r_count == c_full);
    assign bus.mem_ready = !rst && !w_full;
    assign bus.alu_ready = !rst && !w_full && !bus.mem_valid;

    assign w_take_mem = bus.mem_valid && bus.mem_ready;
    assign w_take_alu = bus.alu_valid && bus.alu_ready;
    assign w_in_reg   = w_take_mem ? bus.mem_reg  : bus.alu_reg;
    assign w_in_data  = w_take_mem ? bus.mem_data : bus.alu_data;

    // Writes to register 0 complete the handshake but are dropped here
    assign w_push = (w_take_mem || w_take_alu) && (w_in_reg != '0);
    assign w_pop  = (r_count != '0) && !wr_hold;

    // Write the accepted result into the tail slot
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_reg[r_wr_ptr]  <= w_in_reg;
            r_fifo_data[r_wr_ptr] <= w_in_data;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Pop the head onto the write port; address/data hold when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_pop;
            if (w_pop) begin
                r_wreg  <= r_fifo_reg[r_rd_ptr];
                r_wdata <= r_fifo_data[r_rd_ptr];
            end
        end
    end

    assign bus.RegWriteSig = r_we;
    assign bus.writeReg    = r_wreg;
    assign bus.writeData   = r_wdata;
    assign count           = r_count;

    // A slot is live when its distance from the head is below the occupancy
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [PTR_W-1:0] c_idx = PTR_W'(gi);
            logic [PTR_W-1:0] w_off;
            assign w_off             = c_idx - r_rd_ptr;
            assign w_entry_valid[gi] = ({1'b0, w_off} < r_count);
        end
    endgenerate

    // Destinations of live entries plus the write currently on the port
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i]) w_mask[r_fifo_reg[i]] = 1'b1;
        end
        if (r_we) w_mask[r_wreg] = 1'b1;
        w_mask[0] = 1'b0;
    end

    assign pending_mask = w_mask;
    assign stall        = w_mask[rd_reg1] | w_mask[rd_reg2];

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module    : tb_reg_writeback_unit
//  Purpose   : Directed self-checking bench for reg_writeback_unit.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_reg_writeback_unit;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic                       clk;
    logic                       rst;
    logic                       wr_hold;
    logic [ADDR_W-1:0]          rd_reg1;
    logic [ADDR_W-1:0]          rd_reg2;
    logic                       stall;
    logic [(1<<ADDR_W)-1:0]     pending_mask;
    logic [$clog2(DEPTH):0]     count;

    int n_total;
    int n_pass;

    reg_writeback_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    reg_writeback_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .wr_hold      (wr_hold),
        .rd_reg1      (rd_reg1),
        .rd_reg2      (rd_reg2),
        .stall        (stall),
        .pending_mask (pending_mask),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one rising edge and land 2 time units after it
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic port(input string tag, input logic we, input int r, input int d);
        check({tag, "_we"},   64'(bus.RegWriteSig), 64'(we));
        check({tag, "_reg"},  64'(bus.writeReg),    64'(r));
        check({tag, "_data"}, 64'(bus.writeData),   64'(d));
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1; wr_hold = 1'b0; rd_reg1 = '0; rd_reg2 = '0;
        bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;

        // ---------------- reset state ----------------
        settle();
        check("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
        check("rst_mem_ready", 64'(bus.mem_ready), 64'd0);
        port("rst", 1'b0, 0, 0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_mask",  64'(pending_mask), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        step(); step();
        rst = 1'b0;
        settle();
        check("idle_alu_ready", 64'(bus.alu_ready), 64'd1);
        check("idle_mem_ready", 64'(bus.mem_ready), 64'd1);

        // ---------------- single ALU write ----------------
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd20; bus.alu_data = 32'd50; rd_reg2 = 5'd20;
        settle();
        check("t1_alu_ready", 64'(bus.alu_ready), 64'd1);
        check("t1_stall_pre", 64'(stall), 64'd0);
        step();
        bus.alu_valid = 1'b0;
        settle();
        check("t1_count_q",  64'(count), 64'd1);
        check("t1_we_q",     64'(bus.RegWriteSig), 64'd0);
        check("t1_stall_q",  64'(stall), 64'd1);
        step();
        port("t1_wr", 1'b1, 20, 50);
        check("t1_count_wr", 64'(count), 64'd0);
        check("t1_stall_wr", 64'(stall), 64'd1);
        step();
        port("t1_after", 1'b0, 20, 50);
        check("t1_stall_after", 64'(stall), 64'd0);
        rd_reg2 = '0;

        // ---------------- priority mem over alu ----------------
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd3; bus.alu_data = 32'h11;
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd4; bus.mem_data = 32'h22;
        settle();
        check("t2_alu_ready", 64'(bus.alu_ready), 64'd0);
        check("t2_mem_ready", 64'(bus.mem_ready), 64'd1);
        step();
        bus.mem_valid = 1'b0;
        settle();
        check("t2_alu_ready2", 64'(bus.alu_ready), 64'd1);
        step();
        bus.alu_valid = 1'b0;
        port("t2_first", 1'b1, 4, 32'h22);
        step();
        port("t2_second", 1'b1, 3, 32'h11);
        step();
        check("t2_done_we", 64'(bus.RegWriteSig), 64'd0);
        check("t2_done_cnt", 64'(count), 64'd0);

        // ---------------- fill under hold ----------------
        wr_hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.alu_valid = 1'b1; bus.alu_reg = 5'(10 + k); bus.alu_data = 32'(32'h100 + k);
            step();
        end
        check("t3_count_full", 64'(count), 64'd4);
        bus.alu_reg = 5'd14; bus.alu_data = 32'h104;
        settle();
        check("t3_alu_ready_full", 64'(bus.alu_ready), 64'd0);
        check("t3_mem_ready_full", 64'(bus.mem_ready), 64'd0);
        check("t3_mask", 64'(pending_mask), 64'h0000_7C00 & ~64'h4000);
        step();
        check("t3_count_held", 64'(count), 64'd4);
        check("t3_we_held", 64'(bus.RegWriteSig), 64'd0);
        wr_hold = 1'b0;
        settle();
        check("t3_ready_release", 64'(bus.alu_ready), 64'd0);
        step();
        port("t3_w10", 1'b1, 10, 32'h100);
        check("t3_count_a", 64'(count), 64'd3);
        check("t3_ready_open", 64'(bus.alu_ready), 64'd1);
        step();
        bus.alu_valid = 1'b0;
        port("t3_w11", 1'b1, 11, 32'h101);
        check("t3_count_b", 64'(count), 64'd3);
        step();
        port("t3_w12", 1'b1, 12, 32'h102);
        step();
        port("t3_w13", 1'b1, 13, 32'h103);
        step();
        port("t3_w14", 1'b1, 14, 32'h104);
        step();
        check("t3_end_we", 64'(bus.RegWriteSig), 64'd0);
        check("t3_end_cnt", 64'(count), 64'd0);

        // ---------------- reg 0 and same-register ordering ----------------
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd0; bus.alu_data = 32'hFF;
        rd_reg1 = 5'd0; rd_reg2 = 5'd0;
        settle();
        check("t4_r0_ready", 64'(bus.alu_ready), 64'd1);
        step();
        check("t4_r0_count", 64'(count), 64'd0);
        check("t4_r0_mask0", 64'(pending_mask[0]), 64'd0);
        bus.alu_reg = 5'd7; bus.alu_data = 32'd1;
        step();
        check("t4_r0_nowrite", 64'(bus.RegWriteSig), 64'd0);
        check("t4_stall_r0", 64'(stall), 64'd0);
        bus.alu_data = 32'd2;
        step();
        bus.alu_valid = 1'b0;
        port("t4_w7a", 1'b1, 7, 1);
        check("t4_mask7", 64'(pending_mask[7]), 64'd1);
        check("t4_mask0", 64'(pending_mask[0]), 64'd0);
        step();
        port("t4_w7b", 1'b1, 7, 2);
        step();
        check("t4_end_we", 64'(bus.RegWriteSig), 64'd0);

        // ---------------- steady push/pop at count 2, pointer wrap ----------------
        wr_hold = 1'b1;
        for (int r = 1; r <= 2; r++) begin
            bus.mem_valid = 1'b1; bus.mem_reg = 5'(r); bus.mem_data = 32'(32'h200 + r);
            step();
        end
        check("t5_count2", 64'(count), 64'd2);
        wr_hold = 1'b0;
        for (int r = 3; r <= 12; r++) begin
            bus.mem_reg = 5'(r); bus.mem_data = 32'(32'h200 + r);
            step();
            check("t5_count_steady", 64'(count), 64'd2);
            port("t5_stream", 1'b1, r - 2, 32'h200 + r - 2);
        end
        bus.mem_valid = 1'b0;
        step();
        port("t5_tail11", 1'b1, 11, 32'h20B);
        step();
        port("t5_tail12", 1'b1, 12, 32'h20C);
        check("t5_tail_cnt", 64'(count), 64'd0);
        step();

        // ---------------- asynchronous reset mid-operation ----------------
        wr_hold = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd5; bus.alu_data = 32'h55; step();
        bus.alu_reg = 5'd6; bus.alu_data = 32'h66; step();
        bus.alu_reg = 5'd8; bus.alu_data = 32'h88; step();
        wr_hold = 1'b0;
        bus.alu_reg = 5'd9; bus.alu_data = 32'h99;
        step();
        bus.alu_valid = 1'b0;
        port("t6_pre", 1'b1, 5, 32'h55);
        check("t6_pre_cnt", 64'(count), 64'd3);
        rst = 1'b1;
        settle();
        check("t6_rst_we",   64'(bus.RegWriteSig), 64'd0);
        check("t6_rst_cnt",  64'(count), 64'd0);
        check("t6_rst_mask", 64'(pending_mask), 64'd0);
        check("t6_rst_ready", 64'(bus.alu_ready), 64'd0);
        step(); step();
        rst = 1'b0;
        rd_reg1 = 5'd6;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t6_no_stale", 64'(bus.RegWriteSig), 64'd0);
        end
        check("t6_stall6", 64'(stall), 64'd0);
        check("t6_cnt_end", 64'(count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
